// File: rtl/matrix_ctrl_fsm_p_pkg.sv
// Shared state encodings, operation codes and op-legality check for the
// matrix calculator control path.
package matrix_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_MENU    = 4'd1,
        ST_INPUT   = 4'd2,
        ST_GEN     = 4'd3,
        ST_DISPLAY = 4'd4,
        ST_COMPUTE = 4'd5,
        ST_ERROR   = 4'd6,
        ST_SELECT  = 4'd8,
        ST_WAIT    = 4'd9
    } state_e;

    localparam logic [3:0] OP_TRANSPOSE = 4'b0001;
    localparam logic [3:0] OP_ADD       = 4'b0010;
    localparam logic [3:0] OP_SCALAR    = 4'b0100;
    localparam logic [3:0] OP_MATMUL    = 4'b1000;
    localparam logic [3:0] OP_CONV      = 4'b1111;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_TRANSPOSE) || (op == OP_ADD) || (op == OP_SCALAR) ||
               (op == OP_MATMUL) || (op == OP_CONV);
    endfunction

endpackage

// File: rtl/matrix_ctrl_fsm_p_if.sv
// Start/done handshakes between the control FSM (master) and the matrix
// sub-modules (slave).
interface matrix_ctrl_fsm_p_if;
    logic start_input;
    logic start_gen;
    logic start_disp;
    logic start_calc;
    logic input_done;
    logic gen_done;
    logic disp_done;
    logic calc_done;
    logic error_in;

    modport master (
        output start_input, start_gen, start_disp, start_calc,
        input  input_done, gen_done, disp_done, calc_done, error_in
    );

    modport slave (
        input  start_input, start_gen, start_disp, start_calc,
        output input_done, gen_done, disp_done, calc_done, error_in
    );
endinterface

// File: rtl/matrix_ctrl_fsm_p_sec_countdown.sv
// Seconds countdown for the error wait: a CLK_HZ divider stepping sec_out
// down from WAIT_SEC, with a pulse in the cycle the last second expires.
module sec_countdown #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned WAIT_SEC = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] sec_out,
    output logic             done_pulse
);

    localparam int unsigned DIV_W = $clog2(CLK_HZ);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             wrap;

    assign wrap       = (div_q == DIV_W'(CLK_HZ - 1));
    assign done_pulse = enable && wrap && (sec_q == CNT_W'(1));
    assign sec_out    = sec_q;

    always_comb begin
        div_d = div_q;
        sec_d = sec_q;
        if (load) begin
            div_d = '0;
            sec_d = CNT_W'(WAIT_SEC);
        end else if (clear) begin
            div_d = '0;
            sec_d = '0;
        end else if (enable) begin
            if (wrap) begin
                div_d = '0;
                if (sec_q != '0) begin
                    sec_d = sec_q - CNT_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sec_q <= '0;
        end else begin
            div_q <= div_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: rtl/matrix_ctrl_fsm_p.sv
// Top-level control FSM of the matrix calculator: menu, input, generate,
// display, select and compute phases with timeout, retry limit and error wait.
module matrix_ctrl_fsm_p
    import matrix_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned WAIT_SEC     = 10,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned CALC_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_ctrl_fsm_p_if.master  hs,
    input  logic                 button,
    input  logic [3:0]           mode_sel,
    output logic [3:0]           state,
    output logic [3:0]           op_type,
    output logic                 error_led,
    output logic [CNT_W-1:0]     countdown_sec,
    output logic                 countdown_done,
    output logic [3:0]           retry_cnt
);

    localparam int unsigned TO_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;

    state_e          state_q, state_d;
    logic            button_q;
    logic            press;
    logic [3:0]      op_q, op_d;
    logic [3:0]      retry_q, retry_d;
    logic [TO_W-1:0] calc_cnt_q, calc_cnt_d;
    logic            start_input_q, start_gen_q, start_disp_q, start_calc_q;
    logic            cd_load, cd_enable, cd_clear, cd_expired;

    assign press = button && !button_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: state_d = ST_MENU;
            ST_MENU: begin
                if (press) begin
                    case (mode_sel)
                        OP_TRANSPOSE: state_d = ST_INPUT;
                        OP_ADD:       state_d = ST_GEN;
                        OP_SCALAR:    state_d = ST_DISPLAY;
                        OP_MATMUL:    state_d = ST_SELECT;
                        default:      state_d = ST_MENU;
                    endcase
                end
            end
            ST_INPUT:   if (hs.input_done) state_d = ST_MENU;
            ST_GEN:     if (hs.gen_done)   state_d = ST_MENU;
            ST_DISPLAY: if (hs.disp_done)  state_d = ST_MENU;
            ST_SELECT: begin
                if (hs.error_in) begin
                    state_d = ST_ERROR;
                end else if (press) begin
                    if (is_legal_op(mode_sel)) begin
                        op_d    = mode_sel;
                        state_d = ST_COMPUTE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_COMPUTE: begin
                if (hs.error_in) begin
                    state_d = ST_ERROR;
                end else if (hs.calc_done) begin
                    state_d = ST_DISPLAY;
                    retry_d = '0;
                end else if (calc_cnt_q == TO_W'(CALC_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                state_d = ST_WAIT;
                if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
            end
            ST_WAIT: begin
                // A press outranks expiry even in the expiry cycle itself.
                if (press) begin
                    state_d = (retry_q < 4'(MAX_RETRY)) ? ST_SELECT : ST_MENU;
                end else if (cd_expired) begin
                    state_d = ST_MENU;
                end
            end
            default: state_d = ST_MENU;
        endcase
        if ((state_d == ST_MENU) && (state_q != ST_MENU)) retry_d = '0;
    end

    assign calc_cnt_d = (state_q == ST_COMPUTE) ? calc_cnt_q + TO_W'(1) : '0;

    // enable is held off on a press so no expiry pulse competes with it.
    assign cd_enable = (state_q == ST_WAIT) && !press;
    assign cd_load   = (state_d == ST_WAIT) && (state_q != ST_WAIT);
    assign cd_clear  = (state_d != ST_WAIT);

    sec_countdown #(
        .CLK_HZ  (CLK_HZ),
        .WAIT_SEC(WAIT_SEC),
        .CNT_W   (CNT_W)
    ) u_countdown (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cd_load),
        .enable    (cd_enable),
        .clear     (cd_clear),
        .sec_out   (countdown_sec),
        .done_pulse(cd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            button_q      <= 1'b0;
            op_q          <= '0;
            retry_q       <= '0;
            calc_cnt_q    <= '0;
            start_input_q <= 1'b0;
            start_gen_q   <= 1'b0;
            start_disp_q  <= 1'b0;
            start_calc_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            button_q      <= button;
            op_q          <= op_d;
            retry_q       <= retry_d;
            calc_cnt_q    <= calc_cnt_d;
            start_input_q <= (state_d == ST_INPUT)   && (state_q != ST_INPUT);
            start_gen_q   <= (state_d == ST_GEN)     && (state_q != ST_GEN);
            start_disp_q  <= (state_d == ST_DISPLAY) && (state_q != ST_DISPLAY);
            start_calc_q  <= (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
        end
    end

    assign hs.start_input = start_input_q;
    assign hs.start_gen   = start_gen_q;
    assign hs.start_disp  = start_disp_q;
    assign hs.start_calc  = start_calc_q;

    assign state          = state_q;
    assign op_type        = op_q;
    assign retry_cnt      = retry_q;
    assign error_led      = (state_q == ST_ERROR) || (state_q == ST_WAIT);
    assign countdown_done = cd_expired;

endmodule

// File: doc/matrix_ctrl_fsm_p.md
Name: matrix_ctrl_fsm_p

Overview:
Parametrised top-level control FSM for the matrix calculator. It sequences the menu, input, generate, display, select and compute phases. It drives single-cycle start pulses to the matrix sub-modules and waits for their done handshakes. It adds a compute timeout, a bounded error-retry counter and a seconds-resolution countdown for the error wait, which feeds the seven-segment display.

Parameters:
CLK_HZ, 100_000_000, clock cycles per countdown second (minimum 2).
WAIT_SEC, 10, error-wait countdown length in seconds (1..2^CNT_W-1).
CNT_W, 4, width of countdown_sec.
CALC_TIMEOUT, 50_000_000, maximum cycles spent in COMPUTE before a forced error.
MAX_RETRY, 3, maximum consecutive errors before a forced return to MENU (1..15).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
button  in  1  debounced, synchronised confirm level
mode_sel  in  4  menu / operation select switches
input_done  in  1  matrix input module finished
gen_done  in  1  matrix generator finished
disp_done  in  1  UART display finished
calc_done  in  1  compute engine finished
error_in  in  1  operand or dimension error from the compute path
state  out  4  current state encoding
start_input  out  1  one-cycle pulse to the input module
start_gen  out  1  one-cycle pulse to the generator
start_disp  out  1  one-cycle pulse to the display
start_calc  out  1  one-cycle pulse to the compute engine
op_type  out  4  latched operation code
error_led  out  1  high in ERROR and WAIT
countdown_sec  out  CNT_W  seconds remaining in WAIT, 0 elsewhere
countdown_done  out  1  one-cycle pulse when the countdown expires
retry_cnt  out  4  consecutive error count

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; every start_* pulse, countdown_done and error_led are 0; op_type=0; countdown_sec=0; retry_cnt=0; button edge register=0.
- Button handling: press = button & ~button_q, where button_q is button registered. A held button yields exactly one press.
- State encodings: IDLE=0, MENU=1, INPUT=2, GEN=3, DISPLAY=4, COMPUTE=5, ERROR=6, SELECT=8, WAIT=9.
- IDLE -> MENU unconditionally, one cycle after reset release.
- MENU, on press: mode_sel 0001 -> INPUT; 0010 -> GEN; 0100 -> DISPLAY; 1000 -> SELECT. Any other value stays in MENU.
- Entering MENU clears retry_cnt.
- INPUT, GEN and DISPLAY each wait for their matching done input, then go to MENU. A done input asserted in the same cycle as the start pulse is accepted.
- SELECT, on press:
  - mode_sel legal (0001, 0010, 0100, 1000, 1111): latch op_type=mode_sel, go to COMPUTE.
  - Otherwise: go to ERROR; op_type is unchanged.
  - error_in in SELECT (no press needed) -> ERROR.
- COMPUTE:
  - Priority 1: error_in -> ERROR.
  - Priority 2: calc_done -> DISPLAY, and retry_cnt clears.
  - Priority 3: the cycle counter reaches CALC_TIMEOUT-1 -> ERROR.
  - The cycle counter clears on every entry to COMPUTE.
- ERROR: lasts one cycle; retry_cnt increments (saturates at 15); next state is WAIT.
- WAIT:
  - On entry, countdown_sec loads WAIT_SEC and the divider clears.
  - The divider counts 0..CLK_HZ-1. At wrap, countdown_sec decrements.
  - When countdown_sec==1 and the divider wraps: countdown_done pulses, countdown_sec becomes 0, next state is MENU.
  - Total dwell is WAIT_SEC*CLK_HZ cycles.
  - A press before expiry: if retry_cnt < MAX_RETRY go to SELECT, else go to MENU.
  - A press in the expiry cycle takes priority over the expiry.
  - Leaving WAIT forces countdown_sec=0.
- Start pulses: start_X is registered, high only on the first cycle the state register equals X. It is never reasserted while the FSM stays in X; re-entry gives a new pulse.
- error_led = (state==ERROR) or (state==WAIT).
- op_type holds its last latched value in every state; only a legal press in SELECT or reset changes it.
- Unused state encodings recover to MENU on the next cycle.

Decomposition:
- Package matrix_ctrl_pkg holds: the state encoding constants; the op codes OP_TRANSPOSE=0001, OP_ADD=0010, OP_SCALAR=0100, OP_MATMUL=1000, OP_CONV=1111; and a legal-op check function.
- One sub-module, sec_countdown, owns the divider, countdown_sec and countdown_done. Its interface is load, enable, clear, sec_out and done_pulse, parametrised by CLK_HZ, WAIT_SEC and CNT_W.

Test Plan:
- Directed tests use CLK_HZ=10, WAIT_SEC=3, CALC_TIMEOUT=20, MAX_RETRY=2.
- Reset, then press with mode_sel=0001 -> state 0,1,2; start_input high for exactly 1 cycle; input_done -> state=1; a held button gives no second transition.
- MENU with mode_sel=1000 pressed -> SELECT. Then mode_sel=0100 pressed -> op_type=0100, state=5, start_calc 1 cycle. calc_done 5 cycles later -> state=4, start_disp pulse, retry_cnt=0.
- In COMPUTE with no calc_done -> ERROR after 20 cycles, then WAIT. countdown_sec steps 3,2,1 every 10 cycles; countdown_done pulses at cycle 30 of WAIT; state=1; error_led low again.
- Same cycle error_in=1 and calc_done=1 in COMPUTE -> ERROR, retry_cnt=1.
- Press in WAIT with retry_cnt=1 -> SELECT. A second error makes retry_cnt=2; a press in WAIT then -> MENU, retry_cnt=0.
- Assert rst_n low mid-WAIT (countdown_sec=2) -> all outputs immediately at reset values; after release state=0, then 1.
